// File: rtl/jx2_agu_addr_pipe.sv
// jx2_agu_addr_pipe: two-stage load/store address generator (scaled index + displacement,
// then 48-bit carry-select base add) with wrap flag and natural-alignment fault check.
module jx2_agu_addr_pipe #(
    parameter int ADDR_BITS = 48,
    parameter int DISP_BITS = 33
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 exHold,
    input  logic                 exFlush,
    input  logic                 opValid,
    input  logic [63:0]          opBase,
    input  logic [63:0]          opIndex,
    input  logic [DISP_BITS-1:0] opDisp,
    input  logic [1:0]           opScale,
    input  logic [1:0]           opSize,
    input  logic                 opStrict,
    input  logic [5:0]           opTag,
    output logic                 outValid,
    output logic [63:0]          outAddr,
    output logic [1:0]           outSize,
    output logic [5:0]           outTag,
    output logic                 outMisal,
    output logic                 outFault,
    output logic                 outWrap
);
    localparam int SEG  = 16;
    localparam int NSEG = ADDR_BITS / SEG;

    logic                 s1_valid_q, s1_valid_d;
    logic [63:0]          s1_idx_q, s1_idx_d;
    logic [ADDR_BITS-1:0] s1_base_q, s1_base_d;
    logic [1:0]           s1_size_q, s1_size_d;
    logic                 s1_strict_q, s1_strict_d;
    logic [5:0]           s1_tag_q, s1_tag_d;
    logic                 out_valid_q, out_valid_d;
    logic [ADDR_BITS-1:0] out_addr_q, out_addr_d;
    logic [1:0]           out_size_q, out_size_d;
    logic [5:0]           out_tag_q, out_tag_d;
    logic                 out_misal_q, out_misal_d;
    logic                 out_fault_q, out_fault_d;
    logic                 out_wrap_q, out_wrap_d;
    logic                 carry;
    logic [SEG:0]         seg_c0, seg_c1;
    logic [ADDR_BITS-1:0] sum;

    always_comb begin
        s1_valid_d  = opValid & ~exFlush;
        s1_idx_d    = (opIndex << opScale) + {{(64-DISP_BITS){opDisp[DISP_BITS-1]}}, opDisp};
        s1_base_d   = opBase[ADDR_BITS-1:0];
        s1_size_d   = opSize;
        s1_strict_d = opStrict;
        s1_tag_d    = opTag;
    end

    // Each segment precomputes both carry-in results; the lower segment's carry picks one.
    always_comb begin
        carry  = 1'b0;
        sum    = '0;
        seg_c0 = '0;
        seg_c1 = '0;
        for (int i = 0; i < NSEG; i++) begin
            seg_c0 = {1'b0, s1_base_q[i*SEG +: SEG]} + {1'b0, s1_idx_q[i*SEG +: SEG]};
            seg_c1 = {1'b0, s1_base_q[i*SEG +: SEG]} + {1'b0, s1_idx_q[i*SEG +: SEG]} + (SEG+1)'(1);
            {carry, sum[i*SEG +: SEG]} = carry ? seg_c1 : seg_c0;
        end
    end

    always_comb begin
        out_valid_d = s1_valid_q & ~exFlush;
        out_addr_d  = sum;
        out_wrap_d  = carry;
        out_size_d  = s1_size_q;
        out_tag_d   = s1_tag_q;
        out_misal_d = (s1_size_q == 2'd0) ? 1'b0 :
                      (s1_size_q == 2'd1) ? sum[0] :
                      (s1_size_q == 2'd2) ? |sum[1:0] : |sum[2:0];
        out_fault_d = out_misal_d & s1_strict_q & s1_valid_q & ~exFlush;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            s1_base_q   <= '0;
            s1_size_q   <= '0;
            s1_strict_q <= 1'b0;
            s1_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_size_q  <= '0;
            out_tag_q   <= '0;
            out_misal_q <= 1'b0;
            out_fault_q <= 1'b0;
            out_wrap_q  <= 1'b0;
        end else if (!exHold) begin
            s1_valid_q  <= s1_valid_d;
            s1_idx_q    <= s1_idx_d;
            s1_base_q   <= s1_base_d;
            s1_size_q   <= s1_size_d;
            s1_strict_q <= s1_strict_d;
            s1_tag_q    <= s1_tag_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_size_q  <= out_size_d;
            out_tag_q   <= out_tag_d;
            out_misal_q <= out_misal_d;
            out_fault_q <= out_fault_d;
            out_wrap_q  <= out_wrap_d;
        end
    end

    assign outValid = out_valid_q;
    assign outAddr  = {{(64-ADDR_BITS){1'b0}}, out_addr_q};
    assign outSize  = out_size_q;
    assign outTag   = out_tag_q;
    assign outMisal = out_misal_q;
    assign outFault = out_fault_q;
    assign outWrap  = out_wrap_q;
endmodule

// File: tb/tb_jx2_agu_addr_pipe.sv
// tb_jx2_agu_addr_pipe: directed vectors; expected results are queued at issue and
// matched by a monitor whenever a new result is presented.
module tb_jx2_agu_addr_pipe;
    typedef struct packed {
        logic [5:0]  tag;
        logic [63:0] addr;
        logic [1:0]  size;
        logic        misal;
        logic        fault;
        logic        wrap;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        exHold = 1'b0;
    logic        exFlush = 1'b0;
    logic        opValid = 1'b0;
    logic [63:0] opBase = '0;
    logic [63:0] opIndex = '0;
    logic [32:0] opDisp = '0;
    logic [1:0]  opScale = '0;
    logic [1:0]  opSize = '0;
    logic        opStrict = 1'b0;
    logic [5:0]  opTag = '0;
    logic        outValid;
    logic [63:0] outAddr;
    logic [1:0]  outSize;
    logic [5:0]  outTag;
    logic        outMisal;
    logic        outFault;
    logic        outWrap;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   fresh = 1'b0;

    jx2_agu_addr_pipe dut (
        .clock(clock), .reset(reset), .exHold(exHold), .exFlush(exFlush),
        .opValid(opValid), .opBase(opBase), .opIndex(opIndex), .opDisp(opDisp),
        .opScale(opScale), .opSize(opSize), .opStrict(opStrict), .opTag(opTag),
        .outValid(outValid), .outAddr(outAddr), .outSize(outSize), .outTag(outTag),
        .outMisal(outMisal), .outFault(outFault), .outWrap(outWrap)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A result is new only if the last edge actually advanced the pipe.
    always @(posedge clock) fresh <= reset && !exHold;

    always @(negedge clock) begin
        exp_t got, e;
        if (!outValid && outFault) check("fault_without_valid", outFault, 1'b0);
        if (fresh && outValid) begin
            got = {outTag, outAddr, outSize, outMisal, outFault, outWrap};
            if (sb.size() == 0) begin
                check("unexpected_result", {outValid, outTag}, 7'h0);
            end else begin
                e = sb.pop_front();
                check($sformatf("result tag%0h", e.tag), got, e);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [5:0] tag, input logic [63:0] b, input logic [63:0] i,
                         input logic [32:0] d, input logic [1:0] sc, input logic [1:0] sz,
                         input logic st);
        opValid = 1'b1; opTag = tag; opBase = b; opIndex = i;
        opDisp = d; opScale = sc; opSize = sz; opStrict = st;
    endtask

    task automatic expect_res(input logic [5:0] tag, input logic [63:0] addr, input logic [1:0] sz,
                              input logic misal, input logic fault, input logic wrap);
        exp_t e;
        e = {tag, addr, sz, misal, fault, wrap};
        sb.push_back(e);
    endtask

    task automatic idle();
        opValid = 1'b0;
    endtask

    task automatic run_one(input logic [5:0] tag, input logic [63:0] b, input logic [63:0] i,
                           input logic [32:0] d, input logic [1:0] sc, input logic [1:0] sz,
                           input logic st, input logic [63:0] addr, input logic misal,
                           input logic fault, input logic wrap);
        drive(tag, b, i, d, sc, sz, st);
        expect_res(tag, addr, sz, misal, fault, wrap);
        step();
        idle();
        check($sformatf("lat1 tag%0h", tag), outValid, 1'b0);
        step();
        check($sformatf("lat2 tag%0h", tag), {outValid, outTag}, {1'b1, tag});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        check("rst outValid", outValid, 1'b0);
        check("rst outAddr", outAddr, 64'h0);
        check("rst outTag", outTag, 6'h0);
        check("rst outSize", outSize, 2'h0);
        check("rst flags", {outMisal, outFault, outWrap}, 3'b000);
        reset = 1'b1;

        // basic add, carries across segment boundaries, wrap, scale, displacement
        run_one(6'h01, 64'h0000_1000_0000_FFFF, 64'h1, 33'h0, 2'd0, 2'd0, 1'b0,
                64'h0000_1000_0001_0000, 1'b0, 1'b0, 1'b0);
        run_one(6'h02, 64'h0000_0000_FFFF_FFFF, 64'h1, 33'h0, 2'd0, 2'd0, 1'b0,
                64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
        run_one(6'h03, 64'h0000_FFFF_FFFF_FFF8, 64'h2, 33'h1_FFFF_FFF8, 2'd3, 2'd3, 1'b0,
                64'h0, 1'b0, 1'b0, 1'b1);
        run_one(6'h04, 64'h0000_FFFF_FFFF_FFF8, 64'h0, 33'h10, 2'd0, 2'd3, 1'b0,
                64'h8, 1'b0, 1'b0, 1'b1);
        run_one(6'h05, 64'hABCD_0000_0000_0100, 64'hFFFF_0000_0000_0010, 33'h0, 2'd0, 2'd2, 1'b1,
                64'h110, 1'b0, 1'b0, 1'b0);
        run_one(6'h06, 64'h0, 64'hF000_0000_0000_0001, 33'h0, 2'd3, 2'd3, 1'b1,
                64'h8, 1'b0, 1'b0, 1'b0);
        run_one(6'h07, 64'h2000, 64'h10, 33'h1_FFFF_FFDF, 2'd1, 2'd0, 1'b1,
                64'h1FFF, 1'b0, 1'b0, 1'b1);
        // alignment
        run_one(6'h08, 64'h1002, 64'h0, 33'h0, 2'd0, 2'd2, 1'b1, 64'h1002, 1'b1, 1'b1, 1'b0);
        run_one(6'h09, 64'h1002, 64'h0, 33'h0, 2'd0, 2'd2, 1'b0, 64'h1002, 1'b1, 1'b0, 1'b0);
        run_one(6'h0A, 64'h1002, 64'h0, 33'h0, 2'd0, 2'd1, 1'b1, 64'h1002, 1'b0, 1'b0, 1'b0);
        run_one(6'h0B, 64'h1004, 64'h0, 33'h0, 2'd0, 2'd3, 1'b0, 64'h1004, 1'b1, 1'b0, 1'b0);
        run_one(6'h0C, 64'h1001, 64'h0, 33'h0, 2'd0, 2'd1, 1'b1, 64'h1001, 1'b1, 1'b1, 1'b0);

        // hold with three ops back-to-back
        drive(6'h11, 64'h100, 64'h0, 33'h0, 2'd0, 2'd0, 1'b0);
        expect_res(6'h11, 64'h100, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive(6'h12, 64'h200, 64'h0, 33'h0, 2'd0, 2'd0, 1'b0);
        expect_res(6'h12, 64'h200, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive(6'h13, 64'h300, 64'h0, 33'h0, 2'd0, 2'd0, 1'b0);
        expect_res(6'h13, 64'h300, 2'd0, 1'b0, 1'b0, 1'b0);
        exHold = 1'b1;
        check("hold pre", {outValid, outTag, outAddr}, {1'b1, 6'h11, 64'h100});
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("hold cyc%0d", k), {outValid, outTag, outAddr}, {1'b1, 6'h11, 64'h100});
        end
        exHold = 1'b0;
        step();
        idle();
        check("after hold tag12", {outValid, outTag}, {1'b1, 6'h12});
        step();
        check("after hold tag13", {outValid, outTag}, {1'b1, 6'h13});
        step();
        check("after hold drain", outValid, 1'b0);

        // flush: ignored under hold, effective otherwise
        drive(6'h21, 64'h400, 64'h0, 33'h0, 2'd0, 2'd0, 1'b0);
        expect_res(6'h21, 64'h400, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive(6'h22, 64'h500, 64'h0, 33'h0, 2'd0, 2'd0, 1'b0);
        step();
        drive(6'h23, 64'h600, 64'h0, 33'h0, 2'd0, 2'd0, 1'b0);
        exHold = 1'b1;
        exFlush = 1'b1;
        step();
        check("flush under hold", {outValid, outTag}, {1'b1, 6'h21});
        exHold = 1'b0;
        drive(6'h24, 64'h700, 64'h0, 33'h0, 2'd0, 2'd0, 1'b0);
        step();
        check("flush cyc1", outValid, 1'b0);
        exFlush = 1'b0;
        drive(6'h25, 64'h800, 64'h0, 33'h3, 2'd0, 2'd2, 1'b1);
        expect_res(6'h25, 64'h803, 2'd2, 1'b1, 1'b1, 1'b0);
        step();
        idle();
        check("flush cyc2", outValid, 1'b0);
        step();
        check("post flush op", {outValid, outTag}, {1'b1, 6'h25});
        step();

        // reset with both stages occupied and hold asserted
        drive(6'h31, 64'h900, 64'h0, 33'h0, 2'd0, 2'd3, 1'b1);
        expect_res(6'h31, 64'h900, 2'd3, 1'b0, 1'b0, 1'b0);
        step();
        drive(6'h32, 64'h903, 64'h0, 33'h0, 2'd0, 2'd3, 1'b1);
        step();
        drive(6'h33, 64'hA00, 64'h0, 33'h0, 2'd0, 2'd0, 1'b0);
        exHold = 1'b1;
        reset = 1'b0;
        step();
        check("midrst outValid", outValid, 1'b0);
        check("midrst data", {outTag, outAddr, outSize}, 72'h0);
        check("midrst flags", {outMisal, outFault, outWrap}, 3'b000);
        reset = 1'b1;
        exHold = 1'b0;
        run_one(6'h34, 64'h0000_0000_0001_FFFE, 64'h1, 33'h1, 2'd1, 2'd1, 1'b1,
                64'h0000_0000_0002_0001, 1'b1, 1'b1, 1'b0);
        step();

        for (int k = 0; k < 10 && sb.size() != 0; k++) step();
        check("scoreboard drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jx2_agu_addr_pipe.md
Name: jx2_agu_addr_pipe

Overview:
- Two-stage pipelined address-generation front end for the Jx2 load/store path.
- Stage 1 forms the scaled index plus displacement. Stage 2 performs the 48-bit carry-select base+index add, which wraps mod 2^48 and forces the upper 16 bits to zero.
- Stage 2 also checks access alignment.
- Outputs are registered and feed the memory-access stage. Stalls come from the pipeline hold and kills come from the branch flush.

Parameters:
- ADDR_BITS, 48, effective address width; result bits [63:ADDR_BITS] are forced to zero.
- DISP_BITS, 33, signed displacement width; sign-extended to 64 bits.

Ports:
- clock  in  1  core clock, rising edge
- reset  in  1  synchronous, active-low reset
- exHold  in  1  pipeline stall; 1 = all state registers hold
- exFlush  in  1  kill all in-flight ops
- opValid  in  1  new op presented this cycle
- opBase  in  64  base register value
- opIndex  in  64  index register value
- opDisp  in  DISP_BITS  signed displacement
- opScale  in  2  index shift amount 0..3 (x1/x2/x4/x8)
- opSize  in  2  access size 0=byte 1=word 2=dword 3=qword
- opStrict  in  1  1 = misalignment raises fault
- opTag  in  6  op identifier, passed through unchanged
- outValid  out  1  registered result valid
- outAddr  out  64  effective address; bits [63:48] always 0
- outSize  out  2  registered copy of opSize
- outTag  out  6  registered copy of opTag
- outMisal  out  1  address not naturally aligned for outSize
- outFault  out  1  outMisal AND strict AND outValid
- outWrap  out  1  carry out of bit 47 in the stage-2 add

Behaviour:
- Reset (reset=0 at a clock edge):
  - s1Valid, outValid, outMisal, outFault, outWrap clear to 0.
  - outAddr clears to 0, outTag to 0, outSize to 0.
  - Reset overrides hold and flush. Reset mid-operation discards both stages.
- Stage 1, on an edge with exHold=0:
  - s1Valid <= opValid & ~exFlush.
  - s1Idx <= (opIndex << opScale) + sext64(opDisp), computed mod 2^64.
  - s1Base, s1Size, s1Strict, s1Tag are captured.
- Stage 2, on an edge with exHold=0:
  - outValid <= s1Valid & ~exFlush.
  - sum49 = {0,s1Base[47:0]} + {0,s1Idx[47:0]}.
  - The add is split into three 16-bit carry-select segments (carry-0 / carry-1 precompute, select on the lower carry).
  - outAddr <= {16'h0, sum49[47:0]}.
  - outWrap <= sum49[48].
- Alignment check in stage 2 (mask by size):
  - byte: never misaligned.
  - word: addr[0] != 0.
  - dword: addr[1:0] != 0.
  - qword: addr[2:0] != 0.
  - The result registers into outMisal.
  - outFault <= misal & s1Strict & s1Valid & ~exFlush.
- Latency: 2 non-held cycles from opValid to outValid. One new op is accepted per non-held cycle.
- exHold=1: every register keeps its value, including outValid. A registered result remains presented until hold drops.
- exFlush=1 with exHold=0: outValid is 0 and s1Valid is 0 after the edge. Data registers may update, but are don't-care.
- exFlush=1 with exHold=1: hold wins, nothing changes. Flush must be re-asserted on a non-held cycle.
- outMisal, outWrap, outAddr, outSize, outTag are meaningful only when outValid=1. outFault is never 1 while outValid=0.
- Upper 16 bits of opBase and opIndex do not influence outAddr or outWrap.
- The scale shift discards bits shifted past bit 63.

Test Plan:
- Basic add: base=0x0000_1000_0000_FFFF, index=1, scale=0, disp=0, size=0.
  - Expect after 2 cycles: outAddr=0x0000_1000_0001_0000 (carry ripples across segment 0->1), outWrap=0, outMisal=0.
- Wrap and scale: base=0x0000_FFFF_FFFF_FFF8, index=2, scale=3, disp=-8.
  - s1Idx=8, so the sum is 2^48.
  - Expect outAddr=0, outWrap=1.
  - Same base with index=0, disp=0x10: expect outAddr=0x8, outWrap=1.
- Alignment: base=0x1002, index=0, size=2 (dword), strict=1 -> outMisal=1, outFault=1.
  - Same with strict=0 -> outMisal=1, outFault=0.
  - size=1 at 0x1002 -> outMisal=0.
- Hold: issue ops tagged 1, 2, 3 back-to-back, and assert exHold for 3 cycles when tag 1 reaches the output.
  - outValid=1, outTag=1, and outAddr stay stable throughout the hold.
  - Tags 2 and 3 then follow on consecutive cycles with no loss or duplication.
- Flush: two ops in flight, then exFlush=1 on a non-held cycle.
  - The next two cycles show outValid=0.
  - A flush during hold does nothing.
  - A new op issued the cycle after the flush appears 2 cycles later.
- Reset mid-stream: drive reset=0 for one edge with ops in both stages and exHold=1.
  - All outputs return to 0 and outValid=0.
  - After reset=1, the first new op emerges with latency 2.
